wav_sample_feeder: RTL and testbench

WAV_SAMPLE_FEEDER -- requirements
Module: wav_sample_feeder

---
 rtl/wav_sample_feeder.sv | 153 +++++++++++++++
 tb/tb_wav_sample_feeder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wav_sample_feeder.sv
// WAV stream parser: checks a 44-byte RIFF header, then packs
// little-endian PCM bytes into 16-bit samples for a DAC FIFO.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, abort                    begin new stream / cancel to IDLE
//   byte_vld, byte_dat, byte_rdy    source byte handshake
//   dac_full, dac_wr, dac_wdat      DAC FIFO write side
//   busy, done, err, stereo         status
module wav_sample_feeder #(
  parameter bit CHECK_FMT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        byte_rdy,
  input  logic        dac_full,
  output logic        dac_wr,
  output logic [15:0] dac_wdat,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        stereo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA_LO,
    S_DATA_HI,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [5:0]  r_idx;
  logic [31:0] r_rem;
  logic [15:0] r_wdat;
  logic        r_stereo;

  logic        w_acc;
  logic        w_bad;
  logic [31:0] w_rem_hdr;
  logic [31:0] w_rem_dec;

  // {must_check, expected} for each fixed header byte
  function automatic logic [8:0] hdr_exp(input logic [5:0] idx);
    logic [8:0] e;
    case (idx)
      6'd0:  e = {1'b1, 8'h52};
      6'd1:  e = {1'b1, 8'h49};
      6'd2:  e = {1'b1, 8'h46};
      6'd3:  e = {1'b1, 8'h46};
      6'd8:  e = {1'b1, 8'h57};
      6'd9:  e = {1'b1, 8'h41};
      6'd10: e = {1'b1, 8'h56};
      6'd11: e = {1'b1, 8'h45};
      6'd12: e = {1'b1, 8'h66};
      6'd13: e = {1'b1, 8'h6D};
      6'd14: e = {1'b1, 8'h74};
      6'd15: e = {1'b1, 8'h20};
      6'd20: e = {1'b1, 8'h01};
      6'd21: e = {1'b1, 8'h00};
      6'd34: e = {1'b1, 8'h10};
      6'd35: e = {1'b1, 8'h00};
      6'd36: e = {1'b1, 8'h64};
      6'd37: e = {1'b1, 8'h61};
      6'd38: e = {1'b1, 8'h74};
      6'd39: e = {1'b1, 8'h61};
      default: e = 9'h000;
    endcase
    return e;
  endfunction

  logic [8:0] w_exp;

  assign w_exp     = hdr_exp(r_idx);
  assign w_bad     = CHECK_FMT && w_exp[8] && (byte_dat != w_exp[7:0]);
  assign w_acc     = byte_vld && byte_rdy;
  // size as it will be once byte 43 lands
  assign w_rem_hdr = {byte_dat, r_rem[23:0]};
  assign w_rem_dec = r_rem - 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_rem    <= '0;
      r_wdat   <= '0;
      r_stereo <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state  <= S_HDR;
            r_idx    <= '0;
            r_stereo <= 1'b0;
          end
        end
        S_HDR: begin
          if (w_acc) begin
            if (w_bad) begin
              r_state <= S_ERR;
            end else begin
              r_idx <= r_idx + 6'd1;
              if (r_idx == 6'd22)
                r_stereo <= (byte_dat == 8'h02);
              if (r_idx >= 6'd40)
                r_rem[{r_idx[1:0], 3'b000} +: 8] <= byte_dat;
              if (r_idx == 6'd43)
                r_state <= (w_rem_hdr == 32'd0) ? S_DONE : S_DATA_LO;
            end
          end
        end
        S_DATA_LO: begin
          if (w_acc) begin
            r_wdat[7:0] <= byte_dat;
            r_rem       <= w_rem_dec;
            // odd tail byte is dropped
            r_state     <= (w_rem_dec == 32'd0) ? S_DONE : S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (w_acc) begin
            r_wdat[15:8] <= byte_dat;
            r_rem        <= w_rem_dec;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!dac_full)
            r_state <= (r_rem == 32'd0) ? S_DONE : S_DATA_LO;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign byte_rdy = (r_state == S_HDR) || (r_state == S_DATA_LO) ||
                    (r_state == S_DATA_HI);
  assign dac_wr   = (r_state == S_WRITE) && !dac_full;
  assign dac_wdat = r_wdat;
  assign busy     = byte_rdy || (r_state == S_WRITE);
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERR);
  assign stereo   = r_stereo;

endmodule

// File: tb/tb_wav_sample_feeder.sv
// Randomised bench for wav_sample_feeder against a stream-level
// model; instances with and without header checking.
module tb_wav_sample_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic vld = 1'b0;
  logic [7:0] dat = 8'h00;
  logic dac_full = 1'b0;
  logic sel = 1'b0;

  logic rdy0, wr0, busy0, done0, err0, st0;
  logic rdy1, wr1, busy1, done1, err1, st1;
  logic [15:0] wd0, wd1;

  logic rdy, wr, busy, done, err, stereo;
  logic [15:0] wdat;

  always #5 clk = ~clk;

  wav_sample_feeder #(.CHECK_FMT(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .start(start & ~sel), .abort(abort & ~sel),
    .byte_vld(vld & ~sel), .byte_dat(dat), .byte_rdy(rdy0),
    .dac_full(dac_full), .dac_wr(wr0), .dac_wdat(wd0),
    .busy(busy0), .done(done0), .err(err0), .stereo(st0)
  );

  wav_sample_feeder #(.CHECK_FMT(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .start(start & sel), .abort(abort & sel),
    .byte_vld(vld & sel), .byte_dat(dat), .byte_rdy(rdy1),
    .dac_full(dac_full), .dac_wr(wr1), .dac_wdat(wd1),
    .busy(busy1), .done(done1), .err(err1), .stereo(st1)
  );

  assign rdy    = sel ? rdy1  : rdy0;
  assign wr     = sel ? wr1   : wr0;
  assign wdat   = sel ? wd1   : wd0;
  assign busy   = sel ? busy1 : busy0;
  assign done   = sel ? done1 : done0;
  assign err    = sel ? err1  : err0;
  assign stereo = sel ? st1   : st0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [7:0]  s[$];
  logic [15:0] exp_w[$];
  logic [15:0] got[$];

  function automatic logic [7:0] magic(input int i);
    case (i)
      0: return 8'h52; 1: return 8'h49; 2: return 8'h46; 3: return 8'h46;
      8: return 8'h57; 9: return 8'h41; 10: return 8'h56; 11: return 8'h45;
      12: return 8'h66; 13: return 8'h6D; 14: return 8'h74; 15: return 8'h20;
      20: return 8'h01; 21: return 8'h00;
      34: return 8'h10; 35: return 8'h00;
      36: return 8'h64; 37: return 8'h61; 38: return 8'h74; 39: return 8'h61;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit is_chk(input int i);
    return (i < 4) || (i >= 8 && i < 16) || i == 20 || i == 21 ||
           (i >= 34 && i < 40);
  endfunction

  // valid header for `size` data bytes, channel byte `ch`, random payload
  task automatic golden(input int size, input logic [7:0] ch);
    logic [31:0] sz;
    sz = size;
    s = {};
    for (int i = 0; i < 44 + size; i++)
      s.push_back(8'($urandom));
    for (int i = 0; i < 44; i++)
      if (is_chk(i)) s[i] = magic(i);
    s[22] = ch;
    s[40] = sz[7:0];
    s[41] = sz[15:8];
    s[42] = sz[23:16];
    s[43] = sz[31:24];
  endtask

  task automatic model(input bit chkfmt, output bit e_err,
                       output int e_cons, output bit e_st);
    int size;
    e_err = 1'b0;
    e_cons = 44;
    if (chkfmt)
      for (int i = 0; i < 44; i++)
        if (is_chk(i) && s[i] != magic(i)) begin
          e_err = 1'b1;
          e_cons = i + 1;
          break;
        end
    e_st = (e_cons > 22) && (s[22] == 8'h02);
    exp_w = {};
    if (!e_err) begin
      size = int'({s[43], s[42], s[41], s[40]});
      e_cons = 44 + size;
      for (int i = 0; i < size / 2; i++)
        exp_w.push_back({s[44 + 2*i + 1], s[44 + 2*i]});
    end
  endtask

  // full_mode: 0 random full, 1 full for 10 cycles after first write, 2 never
  task automatic run_stream(input bit use1, input int full_mode,
                            input string nm);
    bit e_err, e_st;
    int e_cons, pos, term, last_evt, first_wr, hold_cons;
    sel = use1;
    model(!use1, e_err, e_cons, e_st);
    got = {};
    pos = 0; term = -1; last_evt = -1; first_wr = -1; hold_cons = 0;
    @(negedge clk);
    vld = 1'b0; dac_full = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vld = (pos < s.size()) && ($urandom_range(0, 3) != 0);
      dat = vld ? s[pos] : 8'($urandom);
      case (full_mode)
        0: dac_full = ($urandom_range(0, 2) == 0);
        1: dac_full = (first_wr >= 0) && (cyc > first_wr) &&
                      (cyc <= first_wr + 10);
        default: dac_full = 1'b0;
      endcase
      #1;
      if (done || err) begin
        term = cyc;
        break;
      end
      if (dac_full) chk({nm, "_wr_while_full"}, 32'(wr), 0);
      if (vld && rdy) begin
        pos++;
        last_evt = cyc;
        if (dac_full) hold_cons++;
      end
      if (wr) begin
        got.push_back(wdat);
        last_evt = cyc;
        if (first_wr < 0) first_wr = cyc;
      end
      @(negedge clk);
    end
    vld = 1'b0;
    dac_full = 1'b0;
    chk({nm, "_finished"}, 32'(term >= 0), 1);
    chk({nm, "_err"}, 32'(err), 32'(e_err));
    chk({nm, "_done"}, 32'(done), 32'(!e_err));
    chk({nm, "_consumed"}, 32'(pos), 32'(e_cons));
    chk({nm, "_stereo"}, 32'(stereo), 32'(e_st));
    chk({nm, "_nwrites"}, 32'(got.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      chk({nm, "_sample"}, 32'(got[i]), 32'(exp_w[i]));
    chk({nm, "_end_latency"}, 32'(term), 32'(last_evt + 1));
    chk({nm, "_rdy_end"}, 32'(rdy), 0);
    chk({nm, "_busy_end"}, 32'(busy), 0);
    if (full_mode == 1) chk({nm, "_hold_bytes"}, 32'(hold_cons <= 2), 1);
    if (term < 0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rdy"}, 32'(rdy0), 0);
    chk({nm, "_wr"}, 32'(wr0), 0);
    chk({nm, "_busy"}, 32'(busy0), 0);
    chk({nm, "_done"}, 32'(done0), 0);
    chk({nm, "_err"}, 32'(err0), 0);
    chk({nm, "_stereo"}, 32'(st0), 0);
    chk({nm, "_wdat"}, 32'(wd0), 0);
  endtask

  int pos;

  initial begin
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    golden(4, 8'h01);
    s[44] = 8'h34; s[45] = 8'h12; s[46] = 8'hCD; s[47] = 8'hAB;
    run_stream(1'b0, 2, "mono4");
    chk("mono4_w0", 32'(got.size() > 0 ? got[0] : 16'h0), 32'h1234);
    chk("mono4_w1", 32'(got.size() > 1 ? got[1] : 16'h0), 32'hABCD);

    golden(3, 8'h01);
    s[44] = 8'h01; s[45] = 8'h02; s[46] = 8'h03;
    run_stream(1'b0, 0, "odd3");
    chk("odd3_w0", 32'(got.size() > 0 ? got[0] : 16'h0), 32'h0201);

    golden(8, 8'h02);
    s[0] = 8'h00;
    run_stream(1'b0, 0, "bad0_chk");
    run_stream(1'b1, 0, "bad0_nochk");

    golden(8, 8'h02);
    run_stream(1'b0, 1, "stereo_full");

    // abort while holding a low byte
    sel = 1'b0;
    golden(4, 8'h01);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pos = 0;
    for (int c = 0; c < 200 && pos < 45; c++) begin
      vld = 1'b1;
      dat = s[pos];
      #1;
      if (rdy) pos++;
      @(negedge clk);
    end
    vld = 1'b0;
    abort = 1'b1;
    #1;
    chk("abort_busy_before", 32'(busy0), 1);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_rdy", 32'(rdy0), 0);
    chk("abort_done", 32'(done0), 0);
    chk("abort_err", 32'(err0), 0);
    chk("abort_wr", 32'(wr0), 0);
    golden(6, 8'h02);
    run_stream(1'b0, 0, "after_abort");

    // reset while stalled in WRITE
    golden(2, 8'h02);
    @(negedge clk);
    start = 1'b1;
    dac_full = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pos = 0;
    for (int c = 0; c < 200 && pos < 46; c++) begin
      vld = 1'b1;
      dat = s[pos];
      #1;
      if (rdy0) pos++;
      @(negedge clk);
    end
    vld = 1'b0;
    #1;
    chk("stall_busy", 32'(busy0), 1);
    chk("stall_wr", 32'(wr0), 0);
    #1;
    rst_n = 1'b0;
    dac_full = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_wait_busy", 32'(busy0), 0);

    golden(0, 8'h01);
    run_stream(1'b0, 0, "size0");

    for (int n = 0; n < 25; n++) begin
      golden($urandom_range(0, 12), 8'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, 43);
        if (is_chk(k)) s[k] = s[k] ^ 8'(1 << $urandom_range(0, 7));
      end
      run_stream(1'b0, 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
